softmax_exp_fetch: RTL and testbench
====================================

// Module: softmax_exp_fetch
// PURPOSE
//  Streaming requester for the registered exp(-n) lookup ROM (5-bit address, 16-bit Q1.15 result, 1-cycle latency).
//  Accepts a frame of substrate indices, issues one ROM lookup per index, and returns each result in order.
//  Buffers results in a 3-entry FIFO so the block runs at full throughput while out_ready is held high.
//  Accumulates the softmax denominator (sum of all exp results in the frame) and presents it at frame end.
// PARAMETERS
//  IDX_W    5    ROM address width; in_idx and rom_addr width
//  DATA_W   16   ROM data width; rom_data and out_data width
//  SUM_W    24   denominator accumulator width; saturating
//  LEN_W    7    frame length counter width; max frame = 2^LEN_W-1
// PORTS
//  clk          in   1       clock
//  rst_n        in   1       reset, asynchronous, active-low
//  start        in   1       begin frame; sampled only in IDLE
//  abort        in   1       synchronous flush back to IDLE; priority over all other inputs
//  frame_len    in   LEN_W   number of indices in the frame; latched on start
//  in_valid     in   1       in_idx valid
//  in_idx       in   IDX_W   substrate index
//  in_ready     out  1       block accepts in_idx this cycle
//  rom_addr     out  IDX_W   to ROM address input; combinationally equals in_idx
//  rom_data     in   DATA_W  from ROM registered output; valid 1 cycle after the address edge
//  out_valid    out  1       out_data valid (FIFO not empty)
//  out_data     out  DATA_W  exp result, head of FIFO
//  out_last     out  1       out_data is the final element of the frame
//  out_ready    in   1       downstream accepts out_data
//  sum_valid    out  1       one-cycle pulse: sum_out is final
//  sum_out      out  SUM_W   frame denominator; held until the next start
//  sum_sat      out  1       accumulator saturated in the current frame
//  busy         out  1       state != IDLE
// BEHAVIOUR
//  - Reset: state=IDLE; FIFO empty; pend=0; counters=0.
//    Outputs at reset: in_ready=0, out_valid=0, out_last=0, sum_valid=0, sum_out=0, sum_sat=0, busy=0.
//  - FSM IDLE -> RUN on start with frame_len!=0: latch len, clear sum_out/sum_sat/issued/pushed.
//  - FSM IDLE -> DONE on start with frame_len==0; sum_out=0.
//  - FSM RUN -> DONE in the cycle after the push of element len (all results in FIFO).
//  - FSM DONE: sum_valid=1 for exactly this cycle; next state IDLE. FIFO may still hold data; draining is independent.
//  - start is ignored outside IDLE. A start in IDLE while the FIFO is non-empty is legal; FIFO order is preserved.
//  - Accept: in_valid && in_ready. in_ready = (state==RUN) && (issued<len) && (occ+pend<3).
//    All terms are registered; no combinational path from out_ready.
//  - Accept cycle: issued++, pend<=1, last_tag<=(issued==len-1).
//  - Push (pend==1): write {last_tag, rom_data} to FIFO, pushed++, sum_out <= sat_add(sum_out, rom_data).
//  - Saturation: if the zero-extended add exceeds 2^SUM_W-1, sum_out=2^SUM_W-1 and sum_sat=1 (sticky until start).
//  - Pop: out_valid && out_ready. Simultaneous push and pop at any occupancy is legal; occ is unchanged.
//  - Latency: in_idx accepted at edge t -> out_data valid after edge t+1 (1-cycle ROM latency, FIFO bypass not required).
//  - Throughput: with out_ready=1, one element per cycle sustained; occ never exceeds 1.
//  - Backpressure: out_ready=0 lets occ+pend reach 3 and in_ready drops. No result is ever dropped or duplicated.
//  - abort: next state IDLE; FIFO flushed; pend cleared. Any ROM data in flight is discarded.
//    sum_valid is not pulsed; sum_out keeps its partial value.
//  - Async reset at any point returns all state to reset values within the reset assertion.
// TESTING
//  - T1, single frame: frame_len=3, idx 0,1,2, out_ready=1 -> out_data 0x8000, 0x2F16, 0x1152.
//    out_last on the 3rd only; sum_out=0xC068; one sum_valid pulse; sum_sat=0.
//  - T2, throughput: frame_len=64, in_valid=1 every cycle, all idx=3 -> in_ready never drops.
//    64 outputs of 0x065F on consecutive cycles; sum_out=0x197C0.
//  - T3, backpressure: frame_len=8, out_ready=0 for 10 cycles -> in_ready falls after 3 accepts.
//    Releasing out_ready yields all 8 results in order with no loss.
//  - T4, saturation: SUM_W=18, frame_len=8, idx 0 -> sum_out=0x3FFFF, sum_sat=1. out_data stream is unaffected.
//  - T5, zero length: start with frame_len=0 -> sum_valid pulses 2 cycles after start, sum_out=0, no outputs.
//  - T6, abort and reset: abort after 2 of 5 accepts -> FIFO empty next cycle, busy=0, no sum_valid.
//    A new frame then works as in T1. rst_n low mid-frame -> all outputs return to reset values.

Source files
------------

// File: rtl/softmax_exp_fetch.sv
// Streaming requester for the registered exp(-n) ROM: one lookup per accepted index,
// in-order results through a 3-entry FIFO, and a saturating per-frame denominator.
module softmax_exp_fetch #(
  parameter int IDX_W  = 5,
  parameter int DATA_W = 16,
  parameter int SUM_W  = 24,
  parameter int LEN_W  = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [LEN_W-1:0]  frame_len,
  input  logic              in_valid,
  input  logic [IDX_W-1:0]  in_idx,
  output logic              in_ready,
  output logic [IDX_W-1:0]  rom_addr,
  input  logic [DATA_W-1:0] rom_data,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  input  logic              out_ready,
  output logic              sum_valid,
  output logic [SUM_W-1:0]  sum_out,
  output logic              sum_sat,
  output logic              busy
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  // Returns {overflow, result}; result clamps to all-ones on overflow.
  function automatic logic [SUM_W:0] sat_add(input logic [SUM_W-1:0] acc,
                                             input logic [DATA_W-1:0] val);
    logic [SUM_W:0] wide;
    wide = {1'b0, acc} + {{(SUM_W + 1 - DATA_W){1'b0}}, val};
    if (wide[SUM_W]) begin
      sat_add = {1'b1, {SUM_W{1'b1}}};
    end else begin
      sat_add = wide;
    end
  endfunction

  function automatic logic [1:0] ptr_next(input logic [1:0] p);
    ptr_next = (p == 2'd2) ? 2'd0 : p + 2'd1;
  endfunction

  logic [1:0]       state_r;
  logic [LEN_W-1:0] len_r;
  logic [LEN_W-1:0] issued_r;
  logic [LEN_W-1:0] pushed_r;
  logic             pend_r;
  logic             last_tag_r;
  logic [DATA_W:0]  mem_r [0:2];
  logic [1:0]       wr_ptr_r;
  logic [1:0]       rd_ptr_r;
  logic [1:0]       occ_r;
  logic [SUM_W-1:0] sum_r;
  logic             sat_r;

  logic             ready_s;
  logic             accept_s;
  logic             push_s;
  logic             pop_s;
  logic [DATA_W:0]  head_s;
  logic [SUM_W:0]   add_s;

  // Slot reservation counts the in-flight ROM read so a full FIFO never overflows.
  assign ready_s  = (state_r == RUN) && (issued_r < len_r) &&
                    (({1'b0, occ_r} + {2'b00, pend_r}) < 3'd3);
  assign accept_s = in_valid && ready_s;
  assign push_s   = pend_r;
  assign pop_s    = (occ_r != 2'd0) && out_ready;
  assign add_s    = sat_add(sum_r, rom_data);

  always_comb begin
    head_s = {(DATA_W + 1){1'b0}};
    case (rd_ptr_r)
      2'd0:    head_s = mem_r[0];
      2'd1:    head_s = mem_r[1];
      2'd2:    head_s = mem_r[2];
      default: head_s = {(DATA_W + 1){1'b0}};
    endcase
  end

  assign in_ready  = ready_s;
  assign rom_addr  = in_idx;
  assign out_valid = (occ_r != 2'd0);
  assign out_data  = head_s[DATA_W-1:0];
  assign out_last  = (occ_r != 2'd0) && head_s[DATA_W];
  assign sum_valid = (state_r == DONE);
  assign sum_out   = sum_r;
  assign sum_sat   = sat_r;
  assign busy      = (state_r != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r    <= IDLE;
      len_r      <= {LEN_W{1'b0}};
      issued_r   <= {LEN_W{1'b0}};
      pushed_r   <= {LEN_W{1'b0}};
      pend_r     <= 1'b0;
      last_tag_r <= 1'b0;
      wr_ptr_r   <= 2'd0;
      rd_ptr_r   <= 2'd0;
      occ_r      <= 2'd0;
      sum_r      <= {SUM_W{1'b0}};
      sat_r      <= 1'b0;
    end else if (abort) begin
      // Flush keeps the partial sum but drops queued and in-flight results.
      state_r  <= IDLE;
      pend_r   <= 1'b0;
      wr_ptr_r <= 2'd0;
      rd_ptr_r <= 2'd0;
      occ_r    <= 2'd0;
    end else begin
      pend_r <= accept_s;
      case (state_r)
        IDLE: begin
          if (start) begin
            len_r    <= frame_len;
            issued_r <= {LEN_W{1'b0}};
            pushed_r <= {LEN_W{1'b0}};
            sum_r    <= {SUM_W{1'b0}};
            sat_r    <= 1'b0;
            state_r  <= (frame_len == {LEN_W{1'b0}}) ? DONE : RUN;
          end
        end
        RUN: begin
          if (push_s && (pushed_r == len_r - LEN_ONE)) begin
            state_r <= DONE;
          end
        end
        DONE:    state_r <= IDLE;
        default: state_r <= IDLE;
      endcase
      if (accept_s) begin
        issued_r   <= issued_r + LEN_ONE;
        last_tag_r <= (issued_r == len_r - LEN_ONE);
      end
      if (push_s) begin
        pushed_r <= pushed_r + LEN_ONE;
        sum_r    <= add_s[SUM_W-1:0];
        sat_r    <= sat_r | add_s[SUM_W];
        wr_ptr_r <= ptr_next(wr_ptr_r);
      end
      if (pop_s) begin
        rd_ptr_r <= ptr_next(rd_ptr_r);
      end
      case ({push_s, pop_s})
        2'b10:   occ_r <= occ_r + 2'd1;
        2'b01:   occ_r <= occ_r - 2'd1;
        default: occ_r <= occ_r;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        mem_r[i] <= {(DATA_W + 1){1'b0}};
      end
    end else if (push_s && !abort) begin
      for (int i = 0; i < 3; i++) begin
        if (wr_ptr_r == 2'(i)) begin
          mem_r[i] <= {last_tag_r, rom_data};
        end
      end
    end
  end

endmodule

// File: tb/tb_softmax_exp_fetch.sv
// Scoreboard bench for softmax_exp_fetch: a default instance plus an SUM_W=18 twin
// fed identically, so saturation can be checked on the same stimulus stream.
module tb_softmax_exp_fetch;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, abort, in_valid, out_ready;
  logic [6:0]  frame_len;
  logic [4:0]  in_idx;
  logic [15:0] rom_data;
  logic        a_in_ready, a_out_valid, a_out_last, a_sum_valid, a_sum_sat, a_busy;
  logic [4:0]  a_rom_addr;
  logic [15:0] a_out_data;
  logic [23:0] a_sum_out;
  logic        b_in_ready, b_out_valid, b_out_last, b_sum_valid, b_sum_sat, b_busy;
  logic [4:0]  b_rom_addr;
  logic [15:0] b_out_data;
  logic [17:0] b_sum_out;

  softmax_exp_fetch dut_a (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .frame_len(frame_len),
    .in_valid(in_valid), .in_idx(in_idx), .in_ready(a_in_ready), .rom_addr(a_rom_addr),
    .rom_data(rom_data), .out_valid(a_out_valid), .out_data(a_out_data),
    .out_last(a_out_last), .out_ready(out_ready), .sum_valid(a_sum_valid),
    .sum_out(a_sum_out), .sum_sat(a_sum_sat), .busy(a_busy));

  softmax_exp_fetch #(.SUM_W(18)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .frame_len(frame_len),
    .in_valid(in_valid), .in_idx(in_idx), .in_ready(b_in_ready), .rom_addr(b_rom_addr),
    .rom_data(rom_data), .out_valid(b_out_valid), .out_data(b_out_data),
    .out_last(b_out_last), .out_ready(out_ready), .sum_valid(b_sum_valid),
    .sum_out(b_sum_out), .sum_sat(b_sum_sat), .busy(b_busy));

  // exp(-n) in Q1.15, truncated; 1-cycle registered ROM
  logic [15:0] rom_tab [0:31];
  initial begin
    for (int n = 0; n < 32; n++) rom_tab[n] = 16'($rtoi($exp(-real'(n)) * 32768.0));
  end
  always @(posedge clk) rom_data <= rom_tab[a_rom_addr];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [16:0] exp_q [$];
  logic [15:0] got_data [$];
  logic        got_last [$];
  int cur_len, acc_cnt, raw_sum, sv_cnt, out_cnt, acc_cyc, fv_cyc, first_pop, last_pop;
  int diff_cnt = 0;
  logic        mpend;
  logic [15:0] mpend_val;

  // Reference model and scoreboard, evaluated on the falling edge
  always @(negedge clk) begin
    if ({a_in_ready, a_out_valid, a_out_data, a_out_last, a_busy, a_sum_valid, a_rom_addr} !==
        {b_in_ready, b_out_valid, b_out_data, b_out_last, b_busy, b_sum_valid, b_rom_addr})
      diff_cnt++;
    if (!rst_n || abort) begin
      exp_q.delete();
      mpend = 1'b0;
    end else begin
      if (a_out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL pop_unexpected got=%h last=%b but no result outstanding", a_out_data, a_out_last);
        end else begin
          logic [16:0] e;
          e = exp_q.pop_front();
          if ({a_out_last, a_out_data} !== e) begin
            errors++;
            $display("FAIL pop_data got last=%b data=%h want last=%b data=%h",
                     a_out_last, a_out_data, e[16], e[15:0]);
          end
        end
        got_data.push_back(a_out_data);
        got_last.push_back(a_out_last);
        out_cnt++;
        if (first_pop < 0) first_pop = cyc;
        last_pop = cyc;
      end
      if (a_out_valid && fv_cyc < 0) fv_cyc = cyc;
      if (mpend) raw_sum += int'(mpend_val);
      mpend = 1'b0;
      if (start && !a_busy) begin
        cur_len = int'(frame_len); acc_cnt = 0; raw_sum = 0; sv_cnt = 0; out_cnt = 0;
        acc_cyc = -1; fv_cyc = -1; first_pop = -1; last_pop = -1;
        got_data.delete(); got_last.delete();
      end
      if (in_valid && a_in_ready) begin
        exp_q.push_back({(acc_cnt == cur_len - 1), rom_tab[in_idx]});
        if (acc_cyc < 0) acc_cyc = cyc;
        acc_cnt++;
        mpend = 1'b1;
        mpend_val = rom_tab[in_idx];
      end
      if (a_sum_valid) sv_cnt++;
    end
  end

  function automatic int sat_to(input int raw, input int w);
    int mx;
    mx = (1 << w) - 1;
    return (raw > mx) ? mx : raw;
  endfunction

  task automatic start_frame(input int len);
    @(posedge clk); #1;
    start = 1'b1; frame_len = 7'(len);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  task automatic send(input int n, input int base, input int step, output int stalls);
    int guard;
    stalls = 0;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_idx = 5'(base + i * step);
      @(negedge clk);
      guard = 0;
      while (!a_in_ready && guard < 200) begin
        @(negedge clk);
        guard++;
      end
      if (guard > 0) stalls++;
      if (guard >= 200) begin
        checks++; errors++;
        $display("FAIL send_timeout in_ready stayed low at element %0d, want accept", i);
      end
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic wait_sum(output int lat);
    @(negedge clk);
    lat = 0;
    while (!a_sum_valid && lat < 300) begin
      @(negedge clk);
      lat++;
    end
    if (lat >= 300) begin
      checks++; errors++;
      $display("FAIL sum_valid_timeout got no pulse in %0d cycles, want one", lat);
    end
  endtask

  task automatic wait_drain();
    int guard;
    guard = 0;
    @(negedge clk);
    while ((a_out_valid || exp_q.size() != 0) && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (guard >= 300) begin
      errors++;
      $display("FAIL drain_timeout got %0d results outstanding, want 0", exp_q.size());
    end
  endtask

  task automatic check_sums(input string tag);
    checks += 4;
    if (a_sum_out !== 24'(sat_to(raw_sum, 24))) begin
      errors++; $display("FAIL %s sum24 got=%h want=%h", tag, a_sum_out, sat_to(raw_sum, 24));
    end
    if (a_sum_sat !== (raw_sum > 24'hFFFFFF)) begin
      errors++; $display("FAIL %s sat24 got=%b want=%b", tag, a_sum_sat, raw_sum > 24'hFFFFFF);
    end
    if (b_sum_out !== 18'(sat_to(raw_sum, 18))) begin
      errors++; $display("FAIL %s sum18 got=%h want=%h", tag, b_sum_out, sat_to(raw_sum, 18));
    end
    if (b_sum_sat !== (raw_sum > 18'h3FFFF)) begin
      errors++; $display("FAIL %s sat18 got=%b want=%b", tag, b_sum_sat, raw_sum > 18'h3FFFF);
    end
  endtask

  task automatic check_idle_outputs(input string tag);
    checks += 2;
    if ({a_in_ready, a_out_valid, a_out_last, a_sum_valid, a_sum_sat, a_busy} !== 6'b0) begin
      errors++;
      $display("FAIL %s flags got rdy/ov/last/sv/sat/busy=%b want 000000", tag,
               {a_in_ready, a_out_valid, a_out_last, a_sum_valid, a_sum_sat, a_busy});
    end
    if (a_sum_out !== 24'h0) begin
      errors++; $display("FAIL %s sum_out got=%h want=000000", tag, a_sum_out);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0; frame_len = 7'd0;
    in_valid = 1'b0; in_idx = 5'd0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 check_idle_outputs("reset_held");
    rst_n = 1'b1;
    @(negedge clk);
    check_idle_outputs("reset_released");
  endtask

  task automatic test_single(input string tag);
    logic [15:0] want [3];
    int st, lat;
    want[0] = 16'h8000; want[1] = 16'h2F16; want[2] = 16'h1152;
    out_ready = 1'b1;
    start_frame(3);
    send(3, 0, 1, st);
    wait_sum(lat);
    wait_drain();
    repeat (3) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (i >= got_data.size() || got_data[i] !== want[i] || got_last[i] !== (i == 2)) begin
        errors++;
        $display("FAIL %s elem%0d got %0d outputs, want data=%h last=%b", tag, i,
                 got_data.size(), want[i], (i == 2));
      end
    end
    checks += 4;
    if (a_sum_out !== 24'h00C068) begin
      errors++; $display("FAIL %s sum got=%h want=00C068", tag, a_sum_out);
    end
    if (a_sum_sat !== 1'b0) begin
      errors++; $display("FAIL %s sat got=%b want=0", tag, a_sum_sat);
    end
    if (sv_cnt !== 1) begin
      errors++; $display("FAIL %s sum_valid_pulses got=%0d want=1", tag, sv_cnt);
    end
    if (fv_cyc - acc_cyc !== 2) begin
      errors++; $display("FAIL %s latency got=%0d want=2", tag, fv_cyc - acc_cyc);
    end
    check_sums(tag);
  endtask

  task automatic test_throughput();
    int st, lat;
    out_ready = 1'b1;
    start_frame(64);
    send(64, 3, 0, st);
    wait_sum(lat);
    wait_drain();
    checks += 4;
    if (st !== 0) begin
      errors++; $display("FAIL thr_stalls got=%0d want=0", st);
    end
    if (out_cnt !== 64) begin
      errors++; $display("FAIL thr_count got=%0d want=64", out_cnt);
    end
    if (last_pop - first_pop !== 63) begin
      errors++; $display("FAIL thr_span got=%0d want=63", last_pop - first_pop);
    end
    if (a_sum_out !== 24'h0197C0) begin
      errors++; $display("FAIL thr_sum got=%h want=0197C0", a_sum_out);
    end
    check_sums("thr");
  endtask

  task automatic test_backpressure();
    int st, lat;
    out_ready = 1'b0;
    start_frame(8);
    fork
      send(8, 1, 3, st);
      begin
        repeat (10) @(negedge clk);
        checks += 2;
        if (acc_cnt !== 3) begin
          errors++; $display("FAIL bp_accepts got=%0d want=3", acc_cnt);
        end
        if (a_in_ready !== 1'b0) begin
          errors++; $display("FAIL bp_in_ready got=%b want=0", a_in_ready);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    wait_sum(lat);
    wait_drain();
    checks++;
    if (out_cnt !== 8) begin
      errors++; $display("FAIL bp_count got=%0d want=8", out_cnt);
    end
    check_sums("bp");
  endtask

  task automatic test_saturation();
    int st, lat;
    out_ready = 1'b1;
    start_frame(8);
    send(8, 0, 0, st);
    wait_sum(lat);
    wait_drain();
    checks += 3;
    if (b_sum_out !== 18'h3FFFF || b_sum_sat !== 1'b1) begin
      errors++; $display("FAIL sat18 got sum=%h sat=%b want sum=3FFFF sat=1", b_sum_out, b_sum_sat);
    end
    if (a_sum_out !== 24'h040000 || a_sum_sat !== 1'b0) begin
      errors++; $display("FAIL sat24 got sum=%h sat=%b want sum=040000 sat=0", a_sum_out, a_sum_sat);
    end
    if (out_cnt !== 8) begin
      errors++; $display("FAIL sat_count got=%0d want=8", out_cnt);
    end
    check_sums("sat");
  endtask

  task automatic test_zero_len();
    int lat;
    out_ready = 1'b1;
    start_frame(0);
    wait_sum(lat);
    repeat (4) @(negedge clk);
    checks += 4;
    if (lat > 2) begin
      errors++; $display("FAIL zero_latency got=%0d want<=2", lat);
    end
    if (a_sum_out !== 24'h0) begin
      errors++; $display("FAIL zero_sum got=%h want=000000", a_sum_out);
    end
    if (out_cnt !== 0) begin
      errors++; $display("FAIL zero_outputs got=%0d want=0", out_cnt);
    end
    if (sv_cnt !== 1 || a_busy !== 1'b0) begin
      errors++; $display("FAIL zero_pulse got pulses=%0d busy=%b want 1 and 0", sv_cnt, a_busy);
    end
  endtask

  task automatic test_abort_reset();
    int st;
    out_ready = 1'b0;
    start_frame(5);
    send(2, 1, 1, st);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    checks += 2;
    if ({a_out_valid, a_busy, a_in_ready} !== 3'b000) begin
      errors++; $display("FAIL abort_flush got ov/busy/rdy=%b want 000", {a_out_valid, a_busy, a_in_ready});
    end
    if (a_sum_out !== 24'h002F16) begin
      errors++; $display("FAIL abort_partial_sum got=%h want=002F16", a_sum_out);
    end
    repeat (5) @(negedge clk);
    checks++;
    if (sv_cnt !== 0) begin
      errors++; $display("FAIL abort_no_pulse got=%0d want=0", sv_cnt);
    end
    test_single("after_abort");
    out_ready = 1'b0;
    start_frame(10);
    send(3, 4, 1, st);
    #2 rst_n = 1'b0;
    #1 check_idle_outputs("midframe_reset");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    out_ready = 1'b1;
    @(negedge clk);
    check_idle_outputs("after_midframe_reset");
  endtask

  initial begin
    test_reset();
    test_single("single");
    test_throughput();
    test_backpressure();
    test_saturation();
    test_zero_len();
    test_abort_reset();
    checks++;
    if (diff_cnt !== 0) begin
      errors++; $display("FAIL twin_consistency got=%0d differing cycles want=0", diff_cnt);
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
